dmem_bridge: RTL and testbench

Data-memory bus bridge sitting directly downstream of the datapath's memory stage. It takes the M-stage access (address, write data, byte write mask) and runs it as one transaction on a split address/data SRAM-like bus (`req`/`addr_ok`/`data_ok`). It returns the read word to the load byte-select logic and holds the pipeline with `mem_stall` until the transaction completes. Read data is buffered, so a completed access is never re-issued while another stall source still holds the pipeline.

---
 rtl/dmem_bridge.sv | 108 ++++++++++
 tb/tb_dmem_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: runs each M-stage load/store as exactly one transaction on a split
// req/addr_ok/data_ok SRAM-like bus, buffers the read word, and holds the
// pipeline with mem_stall until the access is complete.
module dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        ext_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing outstanding
    REQ  = 2'd1,  // request on the bus, waiting for addr_ok
    WAIT = 2'd2,  // accepted, waiting for data_ok
    DONE = 2'd3   // complete, waiting for the pipeline to advance
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       start;
  logic       capture;
  logic [1:0] enc_size;
  logic [1:0] enc_off;

  // The byte offset on the bus is implied by the write mask (and is zero for
  // loads), so the incoming low address bits are intentionally dropped.
  logic addr_lo_unused;
  assign addr_lo_unused = ^mem_addr[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; mem_en only matters in IDLE because the pipeline is frozen elsewhere
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (mem_en) state_nxt = REQ;
      REQ: begin
        if (data_addr_ok && data_data_ok) state_nxt = DONE;
        else if (data_addr_ok)            state_nxt = WAIT;
      end
      WAIT: if (data_data_ok) state_nxt = DONE;
      DONE: if (!ext_stall)   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    data_req  = (state == REQ);
    mem_stall = mem_en && (state != DONE);
    start     = (state == IDLE) && mem_en;
    capture   = ((state == REQ) && data_addr_ok && data_data_ok) ||
                ((state == WAIT) && data_data_ok);
  end

  // Translate the write mask into bus size and byte offset; odd masks fall back to a word write
  always_comb begin
    enc_size = 2'd2;
    enc_off  = 2'd0;
    unique case (mem_wmask)
      4'b0001: begin enc_size = 2'd0; enc_off = 2'd0; end
      4'b0010: begin enc_size = 2'd0; enc_off = 2'd1; end
      4'b0100: begin enc_size = 2'd0; enc_off = 2'd2; end
      4'b1000: begin enc_size = 2'd0; enc_off = 2'd3; end
      4'b0011: begin enc_size = 2'd1; enc_off = 2'd0; end
      4'b1100: begin enc_size = 2'd1; enc_off = 2'd2; end
      default: begin enc_size = 2'd2; enc_off = 2'd0; end
    endcase
  end

  // Request fields are latched once at issue and held stable for the whole transaction
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
    end else if (start) begin
      data_wr    <= |mem_wmask;
      data_size  <= enc_size;
      data_addr  <= {mem_addr[31:2], enc_off};
      data_wdata <= mem_wdata;
    end
  end

  // Read buffer: only load completions update it, so it survives stores and external stalls
  always_ff @(posedge clk) begin
    if (!rst)                     mem_rdata <= 32'd0;
    else if (capture && !data_wr) mem_rdata <= data_rdata;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed scenarios with literal expectations followed by a
// randomized run; a transaction-level model in the bench predicts every output
// and one compare process checks the DUT against it on each falling edge.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic [3:0]  mem_wmask = 4'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        ext_stall = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  dmem_bridge dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ext_stall(ext_stall),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // An access is "busy" from issue until the pipeline moves on; "acc" once the
  // bus has taken the address; "done" once the data phase has finished.
  bit          m_busy = 0, m_acc = 0, m_done = 0;
  bit          m_wr = 0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_rdata = 32'd0;

  // Bus size and byte offset for a write mask, straight from the encoding table
  function automatic logic [3:0] size_off(input logic [3:0] mask);
    case (mask)
      4'h0: return {2'd2, 2'd0};
      4'h1: return {2'd0, 2'd0};
      4'h2: return {2'd0, 2'd1};
      4'h4: return {2'd0, 2'd2};
      4'h8: return {2'd0, 2'd3};
      4'h3: return {2'd1, 2'd0};
      4'hC: return {2'd1, 2'd2};
      default: return {2'd2, 2'd0};
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] so;
    if (!rst) begin
      m_busy = 0; m_acc = 0; m_done = 0; m_wr = 0;
      m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0;
    end else if (!m_busy) begin
      if (mem_en) begin
        so      = size_off(mem_wmask);
        m_busy  = 1; m_acc = 0; m_done = 0;
        m_wr    = (mem_wmask != 4'd0);
        m_size  = so[3:2];
        m_addr  = {mem_addr[31:2], so[1:0]};
        m_wdata = mem_wdata;
      end
    end else if (m_done) begin
      if (!ext_stall) begin
        m_busy = 0; m_acc = 0; m_done = 0;
      end
    end else begin
      if ((m_acc || data_addr_ok) && data_data_ok) begin
        m_done = 1;
        if (!m_wr) m_rdata = data_rdata;
      end
      if (data_addr_ok) m_acc = 1;
    end
  end

  // Single compare process: every output, every cycle
  always @(negedge clk) begin
    chk1("data_req", data_req, m_busy && !m_acc && !m_done);
    chk1("mem_stall", mem_stall, mem_en && !m_done);
    chk1("data_wr", data_wr, m_wr);
    chk("data_size", {30'd0, data_size}, {30'd0, m_size});
    chk("data_addr", data_addr, m_addr);
    chk("data_wdata", data_wdata, m_wdata);
    chk("mem_rdata", mem_rdata, m_rdata);
  end

  // ---------------- directed access driver ----------------
  // addr_ok on REQ cycle index k, data_ok j cycles later (j=0: same cycle),
  // ext_stall held for the first 'hold' DONE cycles.
  task automatic run_access(input logic [3:0] mask, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int k, input int j, input int hold,
                            output int stalls, output int reqs,
                            output int cycles, output int first_req);
    int rc, wc, hl;
    bit fin;
    stalls = 0; reqs = 0; cycles = 0; first_req = -1;
    rc = 0; wc = 0; hl = hold; fin = 0;
    @(posedge clk); #2;
    rst = 1'b1; mem_en = 1'b1; mem_wmask = mask; mem_addr = addr;
    mem_wdata = wd; data_rdata = rd;
    while (!fin) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0; ext_stall = 1'b0;
      if (m_busy && !m_done && !m_acc) begin
        data_addr_ok = (rc == k);
        data_data_ok = data_addr_ok && (j == 0);
        rc++;
      end else if (m_busy && !m_done) begin
        wc++;
        data_data_ok = (wc == j);
      end else if (m_done) begin
        ext_stall = (hl > 0);
        if (hl > 0) hl--;
      end
      #3;
      if (mem_stall) stalls++;
      if (data_req) begin
        reqs++;
        if (first_req < 0) first_req = cycles;
      end
      cycles++;
      if (m_done && !ext_stall) begin
        fin = 1;
      end else if (cycles > 300) begin
        checks++; errors++;
        $display("FAIL access_timeout: got %0d cycles expected completion", cycles);
        fin = 1;
      end else begin
        @(posedge clk); #2;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #2;
    mem_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; ext_stall = 1'b0;
  endtask

  logic [3:0] masks [12] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8,
                             4'h3, 4'hC, 4'hF, 4'h5, 4'h6};

  initial begin
    int st, rq, cy, fr;

    // Reset state, with mem_en raised while reset is still low
    @(posedge clk); #2;
    mem_en = 1'b1;
    #3;
    chk1("rst_req", data_req, 1'b0);
    chk1("rst_stall_follows_en", mem_stall, 1'b1);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1; mem_en = 1'b0;

    // Zero-wait load
    run_access(4'h0, 32'h1000_0006, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, st, rq, cy, fr);
    chk("load_addr", data_addr, 32'h1000_0004);
    chk("load_size", {30'd0, data_size}, 32'd2);
    chk1("load_wr", data_wr, 1'b0);
    chk("load_stall_cycles", st, 2);
    chk("load_req_cycles", rq, 1);
    chk("load_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("model_load_rdata", m_rdata, 32'hDEAD_BEEF);
    idle_cycle();

    // Byte store: addr_ok on the second REQ cycle, data_ok three cycles later
    run_access(4'h4, 32'h0000_0020, 32'h00AB_0000, 32'h5555_5555, 1, 3, 0, st, rq, cy, fr);
    chk("bstore_addr", data_addr, 32'h0000_0022);
    chk("bstore_size", {30'd0, data_size}, 32'd0);
    chk1("bstore_wr", data_wr, 1'b1);
    chk("bstore_wdata", data_wdata, 32'h00AB_0000);
    chk("bstore_stall_cycles", st, 6);
    chk("bstore_rdata_kept", mem_rdata, 32'hDEAD_BEEF);
    idle_cycle();

    // Half stores
    run_access(4'hC, 32'h0000_0040, 32'h1234_0000, 32'h0, 0, 1, 0, st, rq, cy, fr);
    chk("hstore_hi_addr", data_addr, 32'h0000_0042);
    chk("hstore_hi_size", {30'd0, data_size}, 32'd1);
    chk("hstore_hi_stall_cycles", st, 3);
    idle_cycle();
    run_access(4'h3, 32'h0000_0040, 32'h0000_5678, 32'h0, 0, 1, 0, st, rq, cy, fr);
    chk("hstore_lo_addr", data_addr, 32'h0000_0040);
    chk("hstore_lo_size", {30'd0, data_size}, 32'd1);
    idle_cycle();

    // Load completing under a 4-cycle external stall
    run_access(4'h0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 0, 4, st, rq, cy, fr);
    chk("ext_req_cycles", rq, 1);
    chk("ext_stall_cycles", st, 2);
    chk("ext_total_cycles", cy, 7);
    chk("ext_rdata", mem_rdata, 32'hCAFE_F00D);

    // Back-to-back: load immediately followed by a store
    run_access(4'h0, 32'h0000_0200, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, st, rq, cy, fr);
    chk("b2b_first_req_idx", fr, 1);
    run_access(4'hF, 32'h0000_0204, 32'hFEED_FACE, 32'h0, 0, 0, 0, st, rq, cy, fr);
    chk("b2b_second_req_idx", fr, 1);
    chk("b2b_second_addr", data_addr, 32'h0000_0204);
    chk1("b2b_second_wr", data_wr, 1'b1);
    chk("b2b_rdata_kept", mem_rdata, 32'h0BAD_CAFE);

    // Reset while waiting for data_ok
    @(posedge clk); #2;
    mem_en = 1'b1; mem_wmask = 4'h0; mem_addr = 32'h0000_0300; ext_stall = 1'b0;
    @(posedge clk); #2;
    data_addr_ok = 1'b1;
    @(posedge clk); #2;
    data_addr_ok = 1'b0; rst = 1'b0;
    #3;
    chk1("model_in_wait", m_acc && !m_done, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1; mem_en = 1'b0;
    #3;
    chk1("rstwait_req", data_req, 1'b0);
    chk1("rstwait_stall", mem_stall, 1'b0);
    chk("rstwait_rdata", mem_rdata, 32'd0);
    chk("rstwait_addr", data_addr, 32'd0);

    // Randomized traffic with a random-latency slave
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 299) != 0);
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (!m_busy) begin
        mem_en    = ($urandom_range(0, 2) != 0);
        mem_wmask = masks[$urandom_range(0, 11)];
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end else if (!m_done && !m_acc) begin
        data_addr_ok = ($urandom_range(0, 2) == 0);
        data_data_ok = data_addr_ok && ($urandom_range(0, 1) == 1);
      end else if (!m_done) begin
        data_data_ok = ($urandom_range(0, 2) == 0);
      end
      ext_stall  = ($urandom_range(0, 2) == 0);
      data_rdata = $urandom;
    end

    @(posedge clk); #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
